// File: rtl/fp_wire.sv
// fp_wire: shared record types, flag indices, rounding modes and IEEE constants for the rounding back end.
package fp_wire;
  typedef struct packed {
    logic        sig;
    logic [13:0] expo;
    logic [53:0] mant;
    logic [1:0]  rema;
    logic        fmt;
    logic [2:0]  rm;
    logic [2:0]  grs;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        inf;
    logic        zero;
  } fp_rnd_in_type;

  typedef struct packed {
    logic        sig;
    logic [13:0] expo;
    logic [53:0] mant;
    logic        fmt;
    logic [2:0]  rm;
    logic        inexact;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        inf;
    logic        zero;
  } fp_rnd_pipe_s1_type;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [31:0] NAN_S  = 32'h7FC0_0000;
  localparam logic [31:0] INF_S  = 32'h7F80_0000;
  localparam logic [31:0] MAXF_S = 32'h7F7F_FFFF;
  localparam logic [63:0] NAN_D  = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] INF_D  = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] MAXF_D = 64'h7FEF_FFFF_FFFF_FFFF;
  localparam logic [31:0] BOX    = 32'hFFFF_FFFF;
endpackage

// File: rtl/fp_rnd_inc.sv
// fp_rnd_inc: round-up decision from rm/grs and the mantissa increment (combinational).
module fp_rnd_inc
  import fp_wire::*;
(
  input  logic [53:0] mant_i,
  input  logic        fmt_i,
  input  logic        sig_i,
  input  logic [2:0]  rm_i,
  input  logic [2:0]  grs_i,
  output logic [54:0] mant_o,
  output logic        inexact_o
);
  logic [53:0] m;
  logic        up;

  assign m         = fmt_i ? mant_i : {29'd0, mant_i[24:0]};
  assign inexact_o = |grs_i;
  assign up = rm_i == RM_RTZ ? 1'b0 :
              rm_i == RM_RDN ? sig_i & inexact_o :
              rm_i == RM_RUP ? ~sig_i & inexact_o :
              rm_i == RM_RMM ? grs_i[2] :
              grs_i[2] & (m[0] | grs_i[1] | grs_i[0]);
  assign mant_o = {1'b0, m} + {54'd0, up};
endmodule

// File: rtl/fp_rnd_pipe.sv
// fp_rnd_pipe: two-stage IEEE round/normalise/pack back end with valid/ready flow control.
// FP_RND_FTZ_EN: when defined, results with a zero exponent field flush to signed zero.
module fp_rnd_pipe
  import fp_wire::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  fp_rnd_in_type    rnd_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [63:0]      result_o,
  output logic [4:0]       flags_o,
  output logic [TAG_W-1:0] tag_o
);
  fp_rnd_pipe_s1_type s1_d, s1_q;
  logic               s1_v_d, s1_v_q, s2_v_d, s2_v_q, s2_adv, in_fire;
  logic [TAG_W-1:0]   tag1_q, tag2_q;
  logic [63:0]        res_d, res_q;
  logic [4:0]         flg_d, flg_q;
  logic [54:0]        mant_r;
  logic               inexact, unused_bits;
  logic               carry, hidden, big, inf_sel;
  logic [52:0]        m2;
  logic [14:0]        e2, ef;
  logic [63:0]        nan_v, inf_v, max_v, zero_v, norm_v;

  assign unused_bits = ^{rnd_i.rema, mant_r[54]};

  fp_rnd_inc u_inc (
    .mant_i   (rnd_i.mant),
    .fmt_i    (rnd_i.fmt),
    .sig_i    (rnd_i.sig),
    .rm_i     (rnd_i.rm),
    .grs_i    (rnd_i.grs),
    .mant_o   (mant_r),
    .inexact_o(inexact)
  );

  assign s2_adv  = ~s2_v_q | ready_i;
  assign ready_o = ~s1_v_q | s2_adv;
  assign in_fire = valid_i & ready_o;
  assign s1_v_d  = in_fire | (s1_v_q & ~s2_adv);
  assign s2_v_d  = s2_adv ? s1_v_q : s2_v_q;

  assign s1_d = '{sig: rnd_i.sig, expo: rnd_i.expo, mant: mant_r[53:0], fmt: rnd_i.fmt, rm: rnd_i.rm,
                  inexact: inexact, snan: rnd_i.snan, qnan: rnd_i.qnan, dbz: rnd_i.dbz,
                  inf: rnd_i.inf, zero: rnd_i.zero};

  // A rounding carry renormalises by one; a subnormal that rounds up into the hidden bit becomes expo 1.
  always_comb begin
    carry   = s1_q.fmt ? s1_q.mant[53] : s1_q.mant[24];
    m2      = carry ? s1_q.mant[53:1] : s1_q.mant[52:0];
    e2      = {1'b0, s1_q.expo} + {14'd0, carry};
    hidden  = s1_q.fmt ? m2[52] : m2[23];
    ef      = ~hidden ? 15'd0 : e2 == 15'd0 ? 15'd1 : e2;
    big     = s1_q.fmt ? ef >= 15'd2047 : ef >= 15'd255;
    inf_sel = s1_q.rm == RM_RTZ ? 1'b0 :
              s1_q.rm == RM_RDN ? s1_q.sig :
              s1_q.rm == RM_RUP ? ~s1_q.sig : 1'b1;
    nan_v   = s1_q.fmt ? NAN_D : {BOX, NAN_S};
    inf_v   = s1_q.fmt ? {s1_q.sig, INF_D[62:0]} : {BOX, s1_q.sig, INF_S[30:0]};
    max_v   = s1_q.fmt ? {s1_q.sig, MAXF_D[62:0]} : {BOX, s1_q.sig, MAXF_S[30:0]};
    zero_v  = s1_q.fmt ? {s1_q.sig, 63'd0} : {BOX, s1_q.sig, 31'd0};
    norm_v  = s1_q.fmt ? {s1_q.sig, ef[10:0], m2[51:0]} : {BOX, s1_q.sig, ef[7:0], m2[22:0]};
    res_d   = norm_v;
    flg_d   = '0;
    flg_d[FLAG_UF] = s1_q.inexact & (ef == 15'd0);
    flg_d[FLAG_NX] = s1_q.inexact;
    if (s1_q.snan) begin
      res_d = nan_v;
      flg_d = 5'd0;
      flg_d[FLAG_NV] = 1'b1;
    end else if (s1_q.qnan) begin
      res_d = nan_v;
      flg_d = 5'd0;
    end else if (s1_q.dbz) begin
      res_d = inf_v;
      flg_d = 5'd0;
      flg_d[FLAG_DZ] = 1'b1;
    end else if (s1_q.inf) begin
      res_d = inf_v;
      flg_d = 5'd0;
    end else if (s1_q.zero) begin
      res_d = zero_v;
      flg_d = 5'd0;
    end else if (big) begin
      res_d = inf_sel ? inf_v : max_v;
      flg_d = 5'd0;
      flg_d[FLAG_OF] = 1'b1;
      flg_d[FLAG_NX] = 1'b1;
`ifdef FP_RND_FTZ_EN
    end else if (ef == 15'd0 && (s1_q.fmt ? |m2[51:0] : |m2[22:0])) begin
      res_d = zero_v;
      flg_d = 5'd0;
      flg_d[FLAG_UF] = 1'b1;
      flg_d[FLAG_NX] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      tag1_q <= '0;
      res_q  <= '0;
      flg_q  <= '0;
      tag2_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (in_fire) begin
        s1_q   <= s1_d;
        tag1_q <= tag_i;
      end
      if (s2_adv & s1_v_q) begin
        res_q  <= res_d;
        flg_q  <= flg_d;
        tag2_q <= tag1_q;
      end
    end
  end

  assign valid_o  = s2_v_q;
  assign result_o = res_q;
  assign flags_o  = flg_q;
  assign tag_o    = tag2_q;
endmodule

// File: tb/tb_fp_rnd_pipe.sv
// tb_fp_rnd_pipe: directed vector table, stall/reset sequences and a randomized scoreboard run.
`timescale 1ns/1ps
module tb_fp_rnd_pipe;
  import fp_wire::*;

  typedef struct {
    fp_rnd_in_type in;
    logic [63:0]   res;
    logic [4:0]    fl;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b1;
  logic          ready_o, valid_o;
  fp_rnd_in_type rnd_i;
  logic [3:0]    tag_i, tag_o;
  logic [63:0]   result_o;
  logic [4:0]    flags_o;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  fp_rnd_pipe #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .rnd_i(rnd_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .flags_o(flags_o), .tag_o(tag_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: rounds the mantissa as an integer, then packs sign/exponent/fraction by weight.
  function automatic logic [68:0] model(input fp_rnd_in_type r);
    logic [63:0] hid, m, mr, e, emax, fld, box, sgn, inf, nan, res;
    logic        inx, up, g, rr, s;
    int          fb;
    fb   = r.fmt ? 52 : 23;
    hid  = 64'd1 << fb;
    emax = r.fmt ? 64'd2047 : 64'd255;
    box  = r.fmt ? 64'd0 : 64'hFFFF_FFFF_0000_0000;
    sgn  = {63'd0, r.sig} << (r.fmt ? 63 : 31);
    inf  = box | sgn | (emax << fb);
    nan  = r.fmt ? 64'h7FF8_0000_0000_0000 : box | 64'h7FC0_0000;
    if (r.snan) return {5'b10000, nan};
    if (r.qnan) return {5'b00000, nan};
    if (r.dbz) return {5'b01000, inf};
    if (r.inf) return {5'b00000, inf};
    if (r.zero) return {5'b00000, box | sgn};
    {g, rr, s} = r.grs;
    inx = |r.grs;
    m = {10'd0, r.mant} % (hid << 2);
    case (r.rm)
      3'd1: up = 1'b0;
      3'd2: up = r.sig & inx;
      3'd3: up = !r.sig & inx;
      3'd4: up = g;
      default: up = g & (m[0] | rr | s);
    endcase
    mr = m + {63'd0, up};
    e  = {50'd0, r.expo};
    if (mr >= (hid << 1)) begin
      mr = mr >> 1;
      e  = e + 64'd1;
    end
    fld = (mr < hid) ? 64'd0 : (e == 64'd0) ? 64'd1 : e;
    if (fld >= emax) begin
      res = ((r.rm == 3'd1) || (r.rm == 3'd2 && !r.sig) || (r.rm == 3'd3 && r.sig)) ?
            (box | sgn | ((emax - 64'd1) << fb) | (hid - 64'd1)) : inf;
      return {5'b00101, res};
    end
`ifdef FP_RND_FTZ_EN
    if (fld == 64'd0 && (mr % hid) != 64'd0) return {5'b00011, box | sgn};
`endif
    return {3'b000, inx && fld == 64'd0, inx, box | sgn | (fld << fb) | (mr % hid)};
  endfunction

  function automatic fp_rnd_in_type mk(input bit fmt, input bit sig, input int expo, input logic [53:0] mant,
                                       input int rm, input logic [2:0] grs, input logic [4:0] sp);
    fp_rnd_in_type r;
    r = '0;
    r.fmt = fmt;
    r.sig = sig;
    r.expo = 14'(expo);
    r.mant = mant;
    r.rm = 3'(rm);
    r.grs = grs;
    {r.snan, r.qnan, r.dbz, r.inf, r.zero} = sp;
    return r;
  endfunction

  function automatic fp_rnd_in_type rand_rec();
    fp_rnd_in_type r;
    int fb, k, emax;
    r = '0;
    r.fmt  = 1'($urandom_range(1, 0));
    r.sig  = 1'($urandom_range(1, 0));
    r.rm   = 3'($urandom_range(7, 0));
    r.grs  = 3'($urandom_range(7, 0));
    r.rema = 2'($urandom_range(3, 0));
    r.mant = 54'({$urandom, $urandom});
    fb   = r.fmt ? 52 : 23;
    emax = r.fmt ? 2047 : 255;
    k    = $urandom_range(9, 0);
    r.expo = 14'($urandom_range(emax - 1, 1));
    r.mant[fb] = (k != 0);
    r.mant[fb + 1] = 1'b0;
    if (k == 0) r.expo = 14'd0;
    if (k == 1) begin
      r.expo = 14'(emax - 1 - $urandom_range(1, 0));
      for (int i = 0; i < fb; i++) r.mant[i] = 1'b1;
    end
    if (k == 2) {r.snan, r.qnan, r.dbz, r.inf, r.zero} = 5'($urandom_range(31, 1));
    if (k == 3) r.expo = 14'(emax + $urandom_range(1, 0));
    return r;
  endfunction

  task automatic stream(input int nrec, input bit scripted, output int got, output bit saw_full);
    logic [72:0] q[$];
    logic [72:0] exp_e, snap;
    int          acc, cyc;
    bit          hold, stall_prev;
    logic [3:0]  tg;
    got = 0; saw_full = 0; acc = 0; cyc = 0; hold = 0; stall_prev = 0; tg = 4'd3; snap = '0;
    while ((acc < nrec || q.size() > 0) && cyc < 4000) begin
      @(posedge clk); #1;
      if (!hold) begin
        if (acc < nrec && (scripted || $urandom_range(3, 0) != 0)) begin
          rnd_i = rand_rec();
          tag_i = tg;
          tg = tg + 4'd1;
          valid_i = 1'b1;
        end else valid_i = 1'b0;
      end
      ready_i = scripted ? !(cyc >= 3 && cyc < 6) : ($urandom_range(9, 0) < 7);
      @(negedge clk);
      if (stall_prev) chk("hold_stable", {tag_o, flags_o, result_o}, snap);
      if (valid_i && ready_o) begin
        q.push_back({tag_i, model(rnd_i)});
        acc++;
      end
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_output: got tag %h want none", tag_o);
        end else begin
          exp_e = q.pop_front();
          chk("stream", {tag_o, flags_o, result_o}, exp_e);
          got++;
        end
      end
      if (!ready_o) saw_full = 1;
      stall_prev = valid_o && !ready_i;
      snap = {tag_o, flags_o, result_o};
      hold = valid_i && !ready_o;
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    if (cyc >= 4000) begin
      total++; bad++;
      $display("FAIL stream_timeout: got %0d outputs want %0d", got, nrec);
    end
  endtask

  initial begin
    vec_t vt[$];
    int   got;
    bit   full;
    rnd_i = '0;
    tag_i = '0;
    #12;
    chk("rst_valid", 73'(valid_o), 73'(0));
    chk("rst_ready", 73'(ready_o), 73'(1));
    chk("rst_out", {tag_o, flags_o, result_o}, 73'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    vt.push_back('{mk(0,0,127,54'h800000,0,3'b000,5'b0), 64'hFFFFFFFF_3F800000, 5'b00000});
    vt.push_back('{mk(0,0,127,54'h800001,0,3'b100,5'b0), 64'hFFFFFFFF_3F800002, 5'b00001});
    vt.push_back('{mk(0,0,127,54'h800000,0,3'b100,5'b0), 64'hFFFFFFFF_3F800000, 5'b00001});
    vt.push_back('{mk(0,0,127,54'h3FFFFFFE800000,0,3'b000,5'b0), 64'hFFFFFFFF_3F800000, 5'b00000});
    vt.push_back('{mk(0,0,254,54'hFFFFFF,0,3'b110,5'b0), 64'hFFFFFFFF_7F800000, 5'b00101});
    vt.push_back('{mk(0,0,254,54'hFFFFFF,1,3'b110,5'b0), 64'hFFFFFFFF_7F7FFFFF, 5'b00001});
    vt.push_back('{mk(0,0,254,54'hFFFFFF,3,3'b110,5'b0), 64'hFFFFFFFF_7F800000, 5'b00101});
    vt.push_back('{mk(0,1,254,54'hFFFFFF,3,3'b110,5'b0), 64'hFFFFFFFF_FF7FFFFF, 5'b00001});
    vt.push_back('{mk(0,0,255,54'h800000,2,3'b000,5'b0), 64'hFFFFFFFF_7F7FFFFF, 5'b00101});
    vt.push_back('{mk(0,1,127,54'h800000,2,3'b001,5'b0), 64'hFFFFFFFF_BF800001, 5'b00001});
    vt.push_back('{mk(1,0,0,54'h0,0,3'b000,5'b10000), 64'h7FF80000_00000000, 5'b10000});
    vt.push_back('{mk(1,1,0,54'h0,0,3'b000,5'b00100), 64'hFFF00000_00000000, 5'b01000});
    vt.push_back('{mk(0,0,0,54'h0,0,3'b111,5'b01000), 64'hFFFFFFFF_7FC00000, 5'b00000});
    vt.push_back('{mk(0,1,0,54'h0,0,3'b000,5'b00010), 64'hFFFFFFFF_FF800000, 5'b00000});
    vt.push_back('{mk(1,1,0,54'h0,0,3'b000,5'b00001), 64'h80000000_00000000, 5'b00000});
    vt.push_back('{mk(0,0,0,54'h0,0,3'b000,5'b11100), 64'hFFFFFFFF_7FC00000, 5'b10000});
    vt.push_back('{mk(0,0,0,54'h7FFFFF,0,3'b110,5'b0), 64'hFFFFFFFF_00800000, 5'b00001});
    vt.push_back('{mk(1,0,1023,54'h10000000000000,0,3'b000,5'b0), 64'h3FF00000_00000000, 5'b00000});
    vt.push_back('{mk(1,0,1023,54'h1FFFFFFFFFFFFF,4,3'b100,5'b0), 64'h40000000_00000000, 5'b00001});
    vt.push_back('{mk(0,0,127,54'h800001,5,3'b100,5'b0), 64'hFFFFFFFF_3F800002, 5'b00001});
`ifdef FP_RND_FTZ_EN
    vt.push_back('{mk(0,0,0,54'h1,0,3'b000,5'b0), 64'hFFFFFFFF_00000000, 5'b00011});
    vt.push_back('{mk(0,0,0,54'h10,0,3'b010,5'b0), 64'hFFFFFFFF_00000000, 5'b00011});
`else
    vt.push_back('{mk(0,0,0,54'h1,0,3'b000,5'b0), 64'hFFFFFFFF_00000001, 5'b00000});
    vt.push_back('{mk(0,0,0,54'h10,0,3'b010,5'b0), 64'hFFFFFFFF_00000010, 5'b00011});
`endif

    foreach (vt[i]) begin
      @(posedge clk); #1;
      rnd_i = vt[i].in;
      tag_i = 4'(i);
      valid_i = 1'b1;
      ready_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk($sformatf("vec%0d_lat1", i), 73'(valid_o), 73'(0));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 73'(valid_o), 73'(1));
      chk($sformatf("vec%0d_out", i), {tag_o, flags_o, result_o}, {4'(i), vt[i].fl, vt[i].res});
    end
    @(posedge clk); #1;

    stream(8, 1'b1, got, full);
    chk("stall_ready_drop", 73'(full), 73'(1));
    chk("stall_count", 73'(got), 73'(8));

    stream(300, 1'b0, got, full);
    chk("rand_count", 73'(got), 73'(300));

    @(posedge clk); #1;
    ready_i = 1'b0;
    rnd_i = mk(0,0,127,54'h800000,0,3'b000,5'b0);
    tag_i = 4'hA;
    valid_i = 1'b1;
    @(posedge clk); #1;
    tag_i = 4'hB;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("full_ready_low", 73'(ready_o), 73'(0));
    chk("full_valid", 73'(valid_o), 73'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 73'(valid_o), 73'(0));
    chk("midrst_ready", 73'(ready_o), 73'(1));
    chk("midrst_out", {tag_o, flags_o, result_o}, 73'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_empty", 73'(valid_o), 73'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
